bit_perm_engine: RTL and testbench



---
 rtl/bit_perm_engine_if.sv | 27 ++
 rtl/bit_perm_engine.sv | 123 ++++++++++++
 tb/tb_bit_perm_engine.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bit_perm_engine_if.sv
// Handshake bundle for bit_perm_engine.
// Upstream side: in_valid/in_ready/in_mode/in_data.
// Downstream side: out_valid/out_ready/out_data/out_mode.
// master: the environment that offers states and takes results.
// slave:  the permutation engine itself.
interface bit_perm_engine_if #(
    parameter int unsigned DATA_W = 128
);
    logic              in_valid;
    logic              in_ready;
    logic              in_mode;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_mode;

    modport master (
        output in_valid, in_mode, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_mode
    );

    modport slave (
        input  in_valid, in_mode, in_data, out_ready,
        output in_ready, out_valid, out_data, out_mode
    );
endinterface

// File: rtl/bit_perm_engine.sv
// Sequential bit-transpose permutation engine for the bit-permuted MixColumn datapath.
// Each WORD_W-bit word is viewed MSB-first; inverse mode maps output index m = R*j + i
// from input index n = j + S*i, forward mode is the exact inverse. LANES words are
// permuted per cycle, so one DATA_W state takes BEATS cycles.
// Ports:
//   clk   - clock, rising edge
//   rst_n - synchronous active-low reset
//   bus   - valid/ready handshake bundle (slave side), see bit_perm_engine_if
//   busy  - high while the engine is permuting a state
module bit_perm_engine #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned WORD_W = 32,
    parameter int unsigned STRIDE = 4,
    parameter int unsigned LANES  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    bit_perm_engine_if.slave  bus,
    output logic              busy
);
    localparam int unsigned ROWS    = WORD_W / STRIDE;
    localparam int unsigned GROUP_W = WORD_W * LANES;
    localparam int unsigned BEATS   = DATA_W / GROUP_W;
    localparam int unsigned BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [1:0] {s_idle, s_busy, s_done} state_t;

    state_t              state_q;
    logic [BEAT_W-1:0]   beat_q;
    logic [DATA_W-1:0]   work_q;
    logic [DATA_W-1:0]   acc_q;
    logic                mode_q;
    logic [DATA_W-1:0]   out_data_q;
    logic                out_mode_q;

    logic [GROUP_W-1:0]  grp;
    logic [GROUP_W-1:0]  grp_perm;
    logic [DATA_W-1:0]   acc_next;

    function automatic logic [WORD_W-1:0] perm_word(input logic [WORD_W-1:0] w,
                                                    input logic inv);
        logic [WORD_W-1:0] r;
        r = '0;
        for (int i = 0; i < int'(ROWS); i++) begin
            for (int j = 0; j < int'(STRIDE); j++) begin
                if (inv) begin
                    r[WORD_W-1-(ROWS*j+i)] = w[WORD_W-1-(j+STRIDE*i)];
                end else begin
                    r[WORD_W-1-(j+STRIDE*i)] = w[WORD_W-1-(ROWS*j+i)];
                end
            end
        end
        return r;
    endfunction

    // The work register shifts left each beat, so the current group is always at the top.
    // Permuted groups shift into the accumulator from the bottom; after BEATS beats the
    // first group has reached the most-significant position.
    always_comb begin
        grp      = work_q[DATA_W-1 -: GROUP_W];
        grp_perm = '0;
        for (int l = 0; l < int'(LANES); l++) begin
            grp_perm[GROUP_W-1-l*WORD_W -: WORD_W] =
                perm_word(grp[GROUP_W-1-l*WORD_W -: WORD_W], mode_q);
        end
        acc_next = (acc_q << GROUP_W) | DATA_W'(grp_perm);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= s_idle;
            beat_q     <= '0;
            work_q     <= '0;
            acc_q      <= '0;
            mode_q     <= 1'b0;
            out_data_q <= '0;
            out_mode_q <= 1'b0;
        end else begin
            unique case (state_q)
                s_idle: begin
                    if (bus.in_valid) begin
                        work_q  <= bus.in_data;
                        mode_q  <= bus.in_mode;
                        beat_q  <= '0;
                        state_q <= s_busy;
                    end
                end
                s_busy: begin
                    acc_q  <= acc_next;
                    work_q <= work_q << GROUP_W;
                    if (beat_q == LAST_BEAT) begin
                        // Result becomes visible only here, never partially.
                        out_data_q <= acc_next;
                        out_mode_q <= mode_q;
                        state_q    <= s_done;
                    end else begin
                        beat_q <= beat_q + BEAT_W'(1);
                    end
                end
                s_done: begin
                    if (bus.out_ready) begin
                        if (bus.in_valid) begin
                            work_q  <= bus.in_data;
                            mode_q  <= bus.in_mode;
                            beat_q  <= '0;
                            state_q <= s_busy;
                        end else begin
                            state_q <= s_idle;
                        end
                    end
                end
                default: state_q <= s_idle;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == s_idle) || ((state_q == s_done) && bus.out_ready);
    assign bus.out_valid = (state_q == s_done);
    assign bus.out_data  = out_data_q;
    assign bus.out_mode  = out_mode_q;
    assign busy          = (state_q == s_busy);
endmodule

// File: tb/tb_bit_perm_engine.sv
// Self-checking bench for bit_perm_engine: known answers, random round trips,
// back-pressure, reset mid-operation and two extra parameter sets driven alongside.
module tb_bit_perm_engine;
    logic clk;
    logic rst_n;
    logic busy_a, busy_b, busy_c;
    bit   sweep_en;

    int n_chk;
    int n_fail;

    bit_perm_engine_if #(.DATA_W(128)) ia ();
    bit_perm_engine_if #(.DATA_W(128)) ib ();
    bit_perm_engine_if #(.DATA_W(128)) ic ();

    bit_perm_engine #(.DATA_W(128), .WORD_W(32), .STRIDE(4), .LANES(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ia), .busy(busy_a));
    bit_perm_engine #(.DATA_W(128), .WORD_W(32), .STRIDE(4), .LANES(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ib), .busy(busy_b));
    bit_perm_engine #(.DATA_W(128), .WORD_W(64), .STRIDE(8), .LANES(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .bus(ic), .busy(busy_c));

    // Sweep instances follow the main stimulus only when enabled; they never see back-pressure.
    assign ib.in_valid  = ia.in_valid & sweep_en;
    assign ib.in_mode   = ia.in_mode;
    assign ib.in_data   = ia.in_data;
    assign ib.out_ready = 1'b1;
    assign ic.in_valid  = ia.in_valid & sweep_en;
    assign ic.in_mode   = ia.in_mode;
    assign ic.in_data   = ia.in_data;
    assign ic.out_ready = 1'b1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1, "watchdog");
    end

    // Reference: a word is a row-major matrix; inverse reads an R x S matrix out column
    // by column, forward reads an S x R matrix out column by column.
    function automatic logic [127:0] model(input logic mode, input logic [127:0] d,
                                           input int ww, input int s);
        logic [127:0] r;
        bit bits [64];
        int nr, nc, idx;
        r  = '0;
        nr = mode ? ww / s : s;
        nc = mode ? s : ww / s;
        for (int k = 0; k < 128 / ww; k++) begin
            for (int n = 0; n < ww; n++) bits[n] = d[127 - k*ww - n];
            idx = 0;
            for (int c = 0; c < nc; c++) begin
                for (int rr = 0; rr < nr; rr++) begin
                    r[127 - k*ww - idx] = bits[rr*nc + c];
                    idx++;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Results of the most recent run()
    int           lat_a, lat_b, lat_c;
    logic [127:0] res_a, res_b, res_c;
    logic         mode_a;
    logic         busy0;

    // Offer one state while every engine is idle with out_ready high; watch 8 cycles.
    task automatic run(input logic mode, input logic [127:0] data);
        bit sa, sb, sc;
        sa = 0; sb = 0; sc = 0;
        lat_a = -1; lat_b = -1; lat_c = -1;
        ia.in_valid  = 1'b1;
        ia.in_mode   = mode;
        ia.in_data   = data;
        ia.out_ready = 1'b1;
        tick();
        busy0       = busy_a;
        ia.in_valid = 1'b0;
        ia.in_mode  = ~mode;
        ia.in_data  = rand128();
        for (int k = 0; k < 8; k++) begin
            if (!sa && ia.out_valid) begin
                sa = 1; lat_a = k; res_a = ia.out_data; mode_a = ia.out_mode;
            end
            if (!sb && ib.out_valid) begin
                sb = 1; lat_b = k; res_b = ib.out_data;
            end
            if (!sc && ic.out_valid) begin
                sc = 1; lat_c = k; res_c = ic.out_data;
            end
            tick();
        end
    endtask

    task automatic check_sweep(input logic mode, input logic [127:0] data);
        check("lanes4_latency", 128'(lat_b), 128'd1);
        check("lanes4_data", res_b, model(mode, data, 32, 4));
        check("w64_latency", 128'(lat_c), 128'd2);
        check("w64_data", res_c, model(mode, data, 64, 8));
    endtask

    typedef struct {
        string        name;
        logic         mode;
        logic [127:0] din;
        logic [127:0] dout;
    } vec_t;

    initial begin
        vec_t vecs [4];
        logic [127:0] x, y, hold, d2;

        n_chk = 0;
        n_fail = 0;
        sweep_en = 1'b1;
        rst_n = 1'b0;
        ia.in_valid = 1'b0;
        ia.in_mode = 1'b0;
        ia.in_data = '0;
        ia.out_ready = 1'b1;

        vecs[0] = '{"kat_inverse", 1'b1, 128'hf3c5f3c5ccc5ccc503c503c53cc53cc5,
                    128'haabbccddeeff00112233445566778899};
        vecs[1] = '{"kat_forward", 1'b0, 128'haabbccddeeff00112233445566778899,
                    128'hf3c5f3c5ccc5ccc503c503c53cc53cc5};
        vecs[2] = '{"all_zeros", 1'b0, 128'h0, 128'h0};
        vecs[3] = '{"all_ones", 1'b1, {128{1'b1}}, {128{1'b1}}};

        repeat (2) tick();
        rst_n = 1'b1;

        check("reset_in_ready", 128'(ia.in_ready), 128'd1);
        check("reset_out_valid", 128'(ia.out_valid), 128'd0);
        check("reset_out_data", ia.out_data, 128'd0);
        check("reset_out_mode", 128'(ia.out_mode), 128'd0);
        check("reset_busy", 128'(busy_a), 128'd0);

        // Table-driven known answers
        foreach (vecs[v]) begin
            run(vecs[v].mode, vecs[v].din);
            check({vecs[v].name, "_data"}, res_a, vecs[v].dout);
            check({vecs[v].name, "_mode"}, 128'(mode_a), 128'(vecs[v].mode));
            check({vecs[v].name, "_latency"}, 128'(lat_a), 128'd4);
            check({vecs[v].name, "_busy"}, 128'(busy0), 128'd1);
            check_sweep(vecs[v].mode, vecs[v].din);
        end

        // Random round trips; sweep instances checked against the model on both passes
        for (int t = 0; t < 1000; t++) begin
            x = rand128();
            run(1'b0, x);
            check("rand_forward", res_a, model(1'b0, x, 32, 4));
            check_sweep(1'b0, x);
            y = res_a;
            run(1'b1, y);
            check("round_trip", res_a, x);
            check("round_trip_mode", 128'(mode_a), 128'd1);
            check_sweep(1'b1, y);
        end

        // Back-pressure: hold DONE for 10 cycles, then accept a new state in the same cycle
        sweep_en = 1'b0;
        x = rand128();
        ia.out_ready = 1'b0;
        ia.in_valid = 1'b1;
        ia.in_mode = 1'b1;
        ia.in_data = x;
        tick();
        ia.in_valid = 1'b0;
        repeat (4) tick();
        check("bp_out_valid", 128'(ia.out_valid), 128'd1);
        check("bp_data", ia.out_data, model(1'b1, x, 32, 4));
        hold = ia.out_data;
        for (int k = 0; k < 10; k++) begin
            ia.in_valid = 1'b1;
            ia.in_mode = 1'b0;
            ia.in_data = rand128();
            #1;
            if (ia.in_ready !== 1'b0 || ia.out_data !== hold || ia.out_mode !== 1'b1 ||
                ia.out_valid !== 1'b1) begin
                check("bp_hold_in_ready", 128'(ia.in_ready), 128'd0);
                check("bp_hold_data", ia.out_data, hold);
            end else begin
                n_chk++;
            end
            tick();
        end
        d2 = rand128();
        ia.in_data = d2;
        ia.in_mode = 1'b0;
        ia.in_valid = 1'b1;
        ia.out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 128'(ia.in_ready), 128'd1);
        tick();
        ia.in_valid = 1'b0;
        check("bp_reaccept_busy", 128'(busy_a), 128'd1);
        check("bp_reaccept_valid_low", 128'(ia.out_valid), 128'd0);
        repeat (3) tick();
        check("bp_early_valid", 128'(ia.out_valid), 128'd0);
        tick();
        check("bp_second_valid", 128'(ia.out_valid), 128'd1);
        check("bp_second_data", ia.out_data, model(1'b0, d2, 32, 4));
        check("bp_second_mode", 128'(ia.out_mode), 128'd0);
        tick();
        check("bp_pulse_end", 128'(ia.out_valid), 128'd0);

        // Reset at beat 2 of a block; out_data still holds the previous nonzero result
        run(1'b1, rand128());
        ia.in_valid = 1'b1;
        ia.in_mode = 1'b1;
        ia.in_data = rand128();
        tick();
        ia.in_valid = 1'b0;
        repeat (2) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst_mid_out_valid", 128'(ia.out_valid), 128'd0);
        check("rst_mid_out_data", ia.out_data, 128'd0);
        check("rst_mid_out_mode", 128'(ia.out_mode), 128'd0);
        check("rst_mid_in_ready", 128'(ia.in_ready), 128'd1);
        check("rst_mid_busy", 128'(busy_a), 128'd0);
        repeat (6) tick();
        check("rst_mid_no_output", 128'(ia.out_valid), 128'd0);
        sweep_en = 1'b1;
        x = rand128();
        run(1'b0, x);
        check("post_rst_data", res_a, model(1'b0, x, 32, 4));
        check("post_rst_latency", 128'(lat_a), 128'd4);
        check_sweep(1'b0, x);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
